// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - UART transmitter draining a first-word-fall-through FIFO
// Serialises start, WIDTH data bits LSB first, optional even parity and stop bits.
module uart_tx_fifo_drain #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic             stop_idx;
  logic [WIDTH-1:0] shreg;
  logic             par;

  logic             bit_end;
  logic             last_stop;
  logic             pop;
  logic [DIV_W-1:0] div_eff;

  assign bit_end   = (cnt == period - DIV_W'(1));
  assign last_stop = (state == STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
  // A pop may only happen from IDLE or in the final stop cycle, which bounds it to one per frame.
  assign pop       = en_i && !fifo_empty_i && !arst && ((state == IDLE) || last_stop);
  assign div_eff   = (div_i == '0) ? DIV_W'(1) : div_i;
  assign fifo_rd_o = pop;
  assign done_o    = last_stop;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      period   <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
    end else if (pop) begin
      shreg    <= fifo_data_i;
      par      <= ^fifo_data_i;
      period   <= div_eff;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_o     <= 1'b0;
      busy_o   <= 1'b1;
      state    <= START;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        cnt <= cnt + DIV_W'(1);
      end else begin
        cnt <= '0;
        // tx_o is loaded with the level of the bit that begins on this edge.
        case (state)
          START: begin
            state <= DATA;
            tx_o  <= shreg[0];
          end
          DATA: begin
            if (bit_idx == IDX_W'(WIDTH - 1)) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_o  <= par;
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg >> 1;
              tx_o    <= shreg[1];
            end
          end
          PARITY: begin
            state <= STOP;
            tx_o  <= 1'b1;
          end
          STOP: begin
            if (last_stop) begin
              state    <= IDLE;
              busy_o   <= 1'b0;
              tx_o     <= 1'b1;
              stop_idx <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Serial-transmit stage that sits directly downstream of the team's synchronous general-purpose FIFO.
- Pops one word at a time from the FIFO's first-word-fall-through read side and serialises it onto a UART-style line: start bit, WIDTH data bits LSB first, optional even parity, 1 or 2 stop bits.
- Runtime baud divisor.
- Back-to-back frames with no idle gap while the FIFO is non-empty.

Parameters:
- WIDTH, 8, data bits per frame; must match the upstream FIFO width; legal 5..9.
- PARITY_EN, 0, 1 = append an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk, input, 1, clock.
- arst, input, 1, asynchronous active-high reset.
- en_i, input, 1, transmit enable; gates only the start of new frames.
- div_i, input, DIV_W, clk cycles per bit; 0 is treated as 1.
- fifo_data_i, input, WIDTH, head-of-FIFO data; valid while fifo_empty_i = 0.
- fifo_empty_i, input, 1, FIFO empty flag.
- fifo_rd_o, output, 1, single-cycle pop strobe to the FIFO read input.
- tx_o, output, 1, serial line; idle high.
- busy_o, output, 1, frame in progress.
- done_o, output, 1, one-cycle pulse at end of each frame.

Behaviour:
- Reset (arst, asynchronous, active-high; clock clk):
  - tx_o=1; fifo_rd_o=0; busy_o=0; done_o=0.
  - State IDLE; all counters 0.
  - Reset asserted mid-frame aborts immediately: tx_o returns high asynchronously; the partial frame is lost and never retransmitted.
- States: IDLE, START, DATA, PARITY (skipped when PARITY_EN=0), STOP.
- Pop and latch:
  - In IDLE, when en_i=1 and fifo_empty_i=0, fifo_rd_o=1 combinationally for exactly that cycle.
  - In the same cycle, fifo_data_i is latched into the shift register and max(div_i,1) into the bit-period register.
  - Next state is START.
- Pop rules:
  - Never assert fifo_rd_o while fifo_empty_i=1.
  - Never assert it more than once per frame.
- Bit timing:
  - The bit counter counts 0..P-1, where P is the latched period; each line bit is held exactly P cycles.
  - div_i changes take effect only at the next frame's latch.
- Line levels:
  - START drives tx_o=0.
  - DATA drives shift register bit 0 and shifts right after each bit; WIDTH bits total; the data-bit index wraps to 0 at WIDTH-1.
  - PARITY drives the XOR of all latched data bits (even parity).
  - STOP drives tx_o=1 for STOP_BITS*P cycles.
- tx_o is registered: it changes on the clock edge after the pop cycle and on each bit boundary.
- busy_o=1 from the cycle after the pop through the last STOP cycle inclusive.
- Frame end:
  - done_o pulses in the last STOP cycle.
  - In that same cycle, if en_i=1 and fifo_empty_i=0, pop and latch as in IDLE and go directly to START: the next start bit follows the last stop cycle with zero idle cycles.
  - Otherwise go to IDLE.
- Frame length: (1 + WIDTH + PARITY_EN + STOP_BITS) * P cycles; the pop-to-pop interval in back-to-back mode equals this exactly.
- en_i deasserted mid-frame: the current frame completes normally; no new pop occurs.
- fifo_empty_i rising mid-frame: ignored.
- Simultaneous pop in the last STOP cycle and upstream write: the FIFO's own rules apply; this block only samples fifo_empty_i.

Test Plan:
- WIDTH=8, PARITY_EN=0, STOP_BITS=1, div_i=4; FIFO holds 0xA5; en_i=1.
  - One fifo_rd_o pulse.
  - tx_o sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 busy cycles.
  - done_o pulses in cycle 40; line high afterward.
- Same configuration, FIFO holds 0x3C, 0xC3.
  - Second fifo_rd_o exactly 40 cycles after the first.
  - Second start bit immediately after the first stop bit; 80 contiguous busy cycles; two done_o pulses.
- PARITY_EN=1, STOP_BITS=2, div_i=2, data 0x07.
  - Line 0,1,1,1,0,0,0,0,0, parity 1, 1, 1; each bit 2 cycles; 24 cycles per frame.
- div_i=0, data 0x00.
  - Period 1; frame 10 cycles: tx_o low 9 cycles, then high 1 cycle.
- fifo_empty_i=1 with en_i=1 for 50 cycles, or en_i=0 with data present.
  - fifo_rd_o never asserted; tx_o=1; busy_o=0.
- arst asserted at cycle 13 of a div_i=4 frame.
  - tx_o=1 and busy_o=0 immediately.
  - After release with the FIFO non-empty, a new pop occurs on the first cycle with en_i=1, and a complete fresh frame is sent.
